// File: rtl/reg_file_dump_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_file_dump_reader_if
// Description : Output word stream of the register-file dump reader.
//               The master drives {addr_o, data_o} with valid_o.
//               The slave answers with ready_i.
// Revision    : 1.0  initial release
// ============================================================================
interface reg_file_dump_reader_if #(
   parameter int N  = 32,
   parameter int AW = 5
);
   logic [AW-1:0] addr_o;
   logic [N-1:0]  data_o;
   logic          valid_o;
   logic          ready_i;

   modport master (
      output addr_o,
      output data_o,
      output valid_o,
      input  ready_i
   );

   modport slave (
      input  addr_o,
      input  data_o,
      input  valid_o,
      output ready_i
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_dump_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_file_dump_reader
// Description : Walks a register range first..last (wrapping modulo 2**AW).
//               Each register is read through the register-file read port.
//               Every word is emitted as {addr, data} on a valid/ready stream.
//               Emits a one-cycle done pulse after the last word is taken.
// Revision    : 1.0  initial release
// ============================================================================
module reg_file_dump_reader #(
   parameter int N  = 32,
   parameter int AW = 5
) (
   input  wire            clk,
   input  wire            reset,            // asynchronous, active low
   input  wire            start_i,
   input  wire            abort_i,
   input  wire [AW-1:0]   first_reg_i,
   input  wire [AW-1:0]   last_reg_i,
   output logic [AW-1:0]  Read_Register_o,
   input  wire [N-1:0]    Read_Data_i,
   output logic           busy_o,
   output logic           done_o,
   reg_file_dump_reader_if.master dump
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] C_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [AW-1:0] cur_q,   cur_d;
   logic [AW-1:0] last_q,  last_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [N-1:0]  data_q,  data_d;
   logic          valid_q, valid_d;

   // State and datapath registers; reset clears everything at once, even mid-sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic: abort takes priority over a same-cycle accept.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cur_d   = first_reg_i;
               last_d  = last_reg_i;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (abort_i) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               data_d  = Read_Data_i;
               addr_d  = cur_q;
               valid_d = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (abort_i) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else if (dump.ready_i) begin
               valid_d = 1'b0;
               if (cur_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  cur_d   = cur_q + C_ONE;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status and read-port outputs decode directly from the state register.
   always_comb begin
      busy_o          = (state_q == S_FETCH) || (state_q == S_SEND);
      done_o          = (state_q == S_DONE);
      Read_Register_o = busy_o ? cur_q : '0;
      dump.addr_o     = addr_q;
      dump.data_o     = data_q;
      dump.valid_o    = valid_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_dump_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_dump_reader
// Description : Directed self-checking bench for reg_file_dump_reader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_dump_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [4:0]  first;
   logic [4:0]  last;
   logic [4:0]  rr;
   logic [31:0] rd;
   logic        busy;
   logic        done;
   logic [31:0] regs [0:31];

   int total = 0;
   int bad   = 0;

   reg_file_dump_reader_if #(.N(32), .AW(5)) bus ();

   reg_file_dump_reader #(.N(32), .AW(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start),
      .abort_i         (abort),
      .first_reg_i     (first),
      .last_reg_i      (last),
      .Read_Register_o (rr),
      .Read_Data_i     (rd),
      .busy_o          (busy),
      .done_o          (done),
      .dump            (bus)
   );

   // Register file model: combinational read
   assign rd = regs[rr];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Run one sweep, checking every word, stability under stall, latency and done timing.
   task automatic sweep(input logic [4:0] f, input logic [4:0] l, input int stall, input bit poke);
      logic [4:0] span;
      logic [4:0] cur;
      int exp_n, words, cycles, stall_cnt, last_acc, first_valid;
      bit done_seen;
      span = l - f;
      exp_n = int'(span) + 1;
      words = 0; cycles = 0; stall_cnt = 0; last_acc = -10; first_valid = -1;
      done_seen = 0; cur = f;
      @(negedge clk);
      first = f; last = l; start = 1'b1; bus.ready_i = 1'b0;
      while (!done_seen && cycles < 600) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            start = 1'b0;
            check("fetch_busy", busy, 1);
            check("fetch_valid", bus.valid_o, 0);
            check("fetch_raddr", rr, f);
         end
         if (poke && cycles == 3) begin
            start = 1'b1; first = 5'd9; last = 5'd9;
         end else if (poke && cycles == 4) begin
            start = 1'b0;
         end
         if (done) begin
            done_seen = 1;
            check("done_words", words, exp_n);
            check("done_timing", cycles, last_acc + 1);
            check("done_valid", bus.valid_o, 0);
         end else if (bus.valid_o) begin
            if (first_valid < 0) begin
               first_valid = cycles;
               check("first_latency", cycles, 2);
            end
            check("word_addr", bus.addr_o, cur);
            check("word_data", bus.data_o, regs[cur]);
            check("word_busy", busy, 1);
            if (stall_cnt < stall) begin
               bus.ready_i = 1'b0;
               stall_cnt++;
            end else begin
               bus.ready_i = 1'b1;
               stall_cnt = 0;
               words++;
               cur = cur + 5'd1;
               last_acc = cycles;
            end
         end else begin
            bus.ready_i = 1'b0;
         end
      end
      if (!done_seen) check("sweep_timeout", 0, 1);
      @(negedge clk);
      bus.ready_i = 1'b0;
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      int  n;
      bit  got;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[2] = 32'd7; regs[4] = 32'd20; regs[25] = 32'd6; regs[31] = 32'd78;
      reset = 1'b0; start = 1'b0; abort = 1'b0; first = '0; last = '0;
      bus.ready_i = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_raddr", rr, 0);
      check("rst_addr", bus.addr_o, 0);
      check("rst_data", bus.data_o, 0);
      check("rst_valid", bus.valid_o, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b1;

      // Full sweep, always ready
      sweep(5'd0, 5'd31, 0, 1'b0);
      // Back-pressure: 5 stalled cycles per word
      sweep(5'd2, 5'd4, 5, 1'b0);
      // Wrap-around sweep
      sweep(5'd30, 5'd1, 0, 1'b0);
      // Single-word sweep
      sweep(5'd25, 5'd25, 0, 1'b0);
      // start pulse and first/last changes while busy are ignored
      sweep(5'd0, 5'd5, 1, 1'b1);

      // Asynchronous reset while the 3rd word is in SEND
      @(negedge clk);
      first = 5'd0; last = 5'd31; start = 1'b1; bus.ready_i = 1'b1;
      n = 0; got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (bus.valid_o) begin
            n++;
            if (n == 3) begin
               check("pre_rst_addr", bus.addr_o, 2);
               bus.ready_i = 1'b0;
               #2 reset = 1'b0;
               #1;
               check("arst_raddr", rr, 0);
               check("arst_addr", bus.addr_o, 0);
               check("arst_data", bus.data_o, 0);
               check("arst_valid", bus.valid_o, 0);
               check("arst_busy", busy, 0);
               check("arst_done", done, 0);
               got = 1;
            end
         end
      end
      if (!got) check("arst_timeout", 0, 1);
      repeat (2) begin
         @(negedge clk);
         check("arst_hold_done", done, 0);
      end
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_done", done, 0);
      sweep(5'd2, 5'd4, 1, 1'b0);

      // Abort together with ready in SEND
      @(negedge clk);
      first = 5'd0; last = 5'd31; start = 1'b1; bus.ready_i = 1'b0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (bus.valid_o) got = 1;
      end
      if (!got) check("abort_wait_timeout", 0, 1);
      check("abort_pre_addr", bus.addr_o, 0);
      abort = 1'b1; bus.ready_i = 1'b1;
      @(negedge clk);
      abort = 1'b0; bus.ready_i = 1'b0;
      check("abort_valid", bus.valid_o, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_raddr", rr, 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
         check("abort_stay_idle", busy, 0);
      end

      // Abort in FETCH
      first = 5'd4; last = 5'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fetch_abort_pre_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("fetch_abort_busy", busy, 0);
      check("fetch_abort_valid", bus.valid_o, 0);
      @(negedge clk);
      check("fetch_abort_done", done, 0);

      // Reader still fully usable afterwards
      sweep(5'd31, 5'd2, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
